// File: rtl/dm9000a_bus_master.sv
// DM9000A host-bus master: chip power-on reset sequencing, ENET_CLK divider and
// two-phase INDEX/DATA register access behind a valid/ready request port.
module dm9000a_bus_master #(
  parameter int DATA_W       = 16,
  parameter int SETUP_CYC    = 2,
  parameter int STROBE_CYC   = 7,
  parameter int HOLD_CYC     = 1,
  parameter int GAP_CYC      = 2,
  parameter int RST_CYC      = 2000000,
  parameter int POR_WAIT_CYC = 500,
  parameter int CLK_DIV      = 2
) (
  input  logic              clk100,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [7:0]        req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_done,
  output logic              irq,
  output logic [DATA_W-1:0] ENET_DATA_o,
  input  logic [DATA_W-1:0] ENET_DATA_i,
  output logic              ENET_DATA_oe,
  output logic              ENET_CMD,
  output logic              ENET_CS_N,
  output logic              ENET_RD_N,
  output logic              ENET_WR_N,
  output logic              ENET_RST_N,
  output logic              ENET_CLK,
  input  logic              ENET_INT
);

  localparam int M0     = (RST_CYC > POR_WAIT_CYC) ? RST_CYC : POR_WAIT_CYC;
  localparam int M1     = (M0 > STROBE_CYC) ? M0 : STROBE_CYC;
  localparam int M2     = (M1 > SETUP_CYC) ? M1 : SETUP_CYC;
  localparam int M3     = (M2 > HOLD_CYC) ? M2 : HOLD_CYC;
  localparam int M4     = (M3 > GAP_CYC) ? M3 : GAP_CYC;
  localparam int CNT_W  = $clog2(M4 + 1);
  localparam int CDIV_W = $clog2(CLK_DIV + 1);

  typedef enum logic [3:0] {
    RST_HOLD, POR_WAIT, IDLE,
    IDX_SETUP, IDX_STROBE, IDX_HOLD, IDX_GAP,
    DAT_SETUP, DAT_STROBE, DAT_HOLD, DAT_GAP
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cyc_last;
  logic                done;
  logic                wr_q;
  logic [7:0]          addr_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;
  logic                rsp_q, init_q;
  logic [CDIV_W-1:0]   cdiv_q;
  logic                eclk_q;
  logic [1:0]          int_q;

  // Each timed state lasts a fixed number of cycles; cnt_q counts within it.
  always_comb begin
    cyc_last = '0;
    case (state_q)
      RST_HOLD:               cyc_last = CNT_W'(RST_CYC - 1);
      POR_WAIT:               cyc_last = CNT_W'(POR_WAIT_CYC - 1);
      IDX_SETUP, DAT_SETUP:   cyc_last = CNT_W'(SETUP_CYC - 1);
      IDX_STROBE, DAT_STROBE: cyc_last = CNT_W'(STROBE_CYC - 1);
      IDX_HOLD, DAT_HOLD:     cyc_last = CNT_W'(HOLD_CYC - 1);
      IDX_GAP, DAT_GAP:       cyc_last = CNT_W'(GAP_CYC - 1);
      default:                cyc_last = '0;
    endcase
  end

  assign done = (cnt_q == cyc_last);

  always_comb begin
    state_d = state_q;
    case (state_q)
      RST_HOLD:   if (done) state_d = POR_WAIT;
      POR_WAIT:   if (done) state_d = IDLE;
      IDLE:       if (req_valid) state_d = IDX_SETUP;
      IDX_SETUP:  if (done) state_d = IDX_STROBE;
      IDX_STROBE: if (done) state_d = IDX_HOLD;
      IDX_HOLD:   if (done) state_d = IDX_GAP;
      IDX_GAP:    if (done) state_d = DAT_SETUP;
      DAT_SETUP:  if (done) state_d = DAT_STROBE;
      DAT_STROBE: if (done) state_d = DAT_HOLD;
      DAT_HOLD:   if (done) state_d = DAT_GAP;
      DAT_GAP:    if (done) state_d = IDLE;
      default:    state_d = RST_HOLD;
    endcase
    cnt_d = (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk100) begin
    if (!rst_n) begin
      state_q <= RST_HOLD;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rsp_q   <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rsp_q   <= (state_q == DAT_GAP) && done;
      init_q  <= init_q | (state_d == IDLE);
      if (state_q == IDLE && req_valid) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      // Sample read data on the final strobe cycle, while RD_N is still low.
      if (state_q == DAT_STROBE && done && !wr_q)
        rdata_q <= ENET_DATA_i;
    end
  end

  always_comb begin
    ENET_CS_N    = 1'b1;
    ENET_WR_N    = 1'b1;
    ENET_RD_N    = 1'b1;
    ENET_CMD     = 1'b1;
    ENET_DATA_oe = 1'b0;
    ENET_DATA_o  = '0;
    ENET_RST_N   = 1'b1;
    req_ready    = 1'b0;
    case (state_q)
      RST_HOLD: ENET_RST_N = 1'b0;
      IDLE:     req_ready  = 1'b1;
      IDX_SETUP, IDX_STROBE, IDX_HOLD: begin
        ENET_CS_N    = 1'b0;
        ENET_CMD     = 1'b0;
        ENET_DATA_oe = 1'b1;
        ENET_DATA_o  = DATA_W'(addr_q);
        ENET_WR_N    = (state_q != IDX_STROBE);
      end
      IDX_GAP: begin
        ENET_CMD    = 1'b0;
        ENET_DATA_o = DATA_W'(addr_q);
      end
      DAT_SETUP, DAT_STROBE, DAT_HOLD: begin
        ENET_CS_N    = 1'b0;
        ENET_DATA_oe = wr_q;
        ENET_DATA_o  = wr_q ? wdata_q : '0;
        ENET_WR_N    = !(state_q == DAT_STROBE && wr_q);
        ENET_RD_N    = !(state_q == DAT_STROBE && !wr_q);
      end
      DAT_GAP:  ENET_DATA_o = wr_q ? wdata_q : '0;
      default: ;
    endcase
  end

  // Free-running chip clock divider, independent of the access FSM.
  always_ff @(posedge clk100) begin
    if (!rst_n) begin
      cdiv_q <= '0;
      eclk_q <= 1'b0;
    end else if (cdiv_q == CDIV_W'(CLK_DIV - 1)) begin
      cdiv_q <= '0;
      eclk_q <= ~eclk_q;
    end else begin
      cdiv_q <= cdiv_q + 1'b1;
    end
  end

  always_ff @(posedge clk100) begin
    if (!rst_n) int_q <= 2'b00;
    else        int_q <= {int_q[0], ENET_INT};
  end

  assign rsp_valid = rsp_q;
  assign rsp_rdata = rdata_q;
  assign init_done = init_q;
  assign irq       = int_q[1];
  assign ENET_CLK  = eclk_q;

endmodule

// File: tb/tb_dm9000a_bus_master.sv
// Directed/randomised bench for dm9000a_bus_master; expected bus waveforms are
// computed from the access timing rules as offsets from the acceptance edge.
module tb_dm9000a_bus_master;
  localparam int DW = 16, S = 2, ST = 7, H = 1, G = 2, RC = 10, PW = 5, CD = 2;
  localparam int PH = S + ST + H + G;
  localparam int T  = 2 * PH;

  logic          clk100 = 1'b0, rst_n = 1'b0, req_valid = 1'b0, req_write = 1'b0;
  logic [7:0]    req_addr = '0;
  logic [DW-1:0] req_wdata = '0, chip_val = '0;
  logic          req_ready, rsp_valid, init_done, irq;
  logic [DW-1:0] rsp_rdata, ENET_DATA_o, ENET_DATA_i;
  logic          ENET_DATA_oe, ENET_CMD, ENET_CS_N, ENET_RD_N, ENET_WR_N, ENET_RST_N, ENET_CLK;
  logic          ENET_INT = 1'b0;

  int            vecs = 0, errs = 0;
  logic [DW-1:0] rdata_ref = '0;
  logic          prev_stb = 1'b0, prev_cmd = 1'b1;
  logic [DW-1:0] prev_data = '0;

  dm9000a_bus_master #(.DATA_W(DW), .SETUP_CYC(S), .STROBE_CYC(ST), .HOLD_CYC(H),
    .GAP_CYC(G), .RST_CYC(RC), .POR_WAIT_CYC(PW), .CLK_DIV(CD)) dut (
    .clk100(clk100), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .init_done(init_done), .irq(irq),
    .ENET_DATA_o(ENET_DATA_o), .ENET_DATA_i(ENET_DATA_i), .ENET_DATA_oe(ENET_DATA_oe),
    .ENET_CMD(ENET_CMD), .ENET_CS_N(ENET_CS_N), .ENET_RD_N(ENET_RD_N),
    .ENET_WR_N(ENET_WR_N), .ENET_RST_N(ENET_RST_N), .ENET_CLK(ENET_CLK),
    .ENET_INT(ENET_INT));

  // Chip model: real data only while RD_N is low, inverted garbage otherwise.
  assign ENET_DATA_i = ENET_RD_N ? ~chip_val : chip_val;

  always #5 clk100 = ~clk100;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic stb;
    @(posedge clk100); #1;
    chk("strobe_excl", 64'(!ENET_WR_N && !ENET_RD_N), 64'd0);
    stb = !ENET_WR_N || !ENET_RD_N;
    if (stb && prev_stb)
      chk("cmd_data_stable", {ENET_CMD, ENET_DATA_o}, {prev_cmd, prev_data});
    prev_stb  = stb;
    prev_cmd  = ENET_CMD;
    prev_data = ENET_DATA_o;
  endtask

  // Expected pins k cycles after acceptance:
  // {CS_N, WR_N, RD_N, CMD, OE, DATA(if OE), rsp_valid, req_ready, init_done, RST_N}
  function automatic logic [24:0] model(input int k, input bit w, input logic [7:0] a,
                                        input logic [DW-1:0] d);
    int j; bit dat, stb, gap, oe;
    logic [DW-1:0] data;
    j   = k % PH;
    dat = (k >= PH);
    stb = (j >= S) && (j < S + ST);
    gap = (j >= S + ST + H);
    oe  = !gap && (!dat || w);
    data = !oe ? '0 : (dat ? d : {8'h00, a});
    return {gap, !(stb && (!dat || w)), !(stb && dat && !w), dat, oe, data,
            1'b0, 1'b0, 1'b1, 1'b1};
  endfunction

  function automatic logic [24:0] observed();
    return {ENET_CS_N, ENET_WR_N, ENET_RD_N, ENET_CMD, ENET_DATA_oe,
            ENET_DATA_oe ? ENET_DATA_o : 16'h0000, rsp_valid, req_ready, init_done, ENET_RST_N};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_state", {ENET_RST_N, ENET_RD_N, ENET_WR_N, ENET_CS_N, ENET_CMD, ENET_DATA_oe,
                          ENET_DATA_o, ENET_CLK, req_ready, rsp_valid, rsp_rdata, init_done, irq},
                         {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0,
                          1'b0, 1'b0});
    end
    rdata_ref = '0;
    rst_n = 1'b1;
    for (int n = 0; n < RC + PW; n++) begin
      chk("rst_pin", 64'(ENET_RST_N), 64'(n >= RC));
      chk("init_hold", {init_done, req_ready, ENET_CS_N, rsp_valid}, 4'b0010);
      chk("enet_clk", 64'(ENET_CLK), 64'((n / CD) % 2));
      tick();
    end
    chk("init_done", {init_done, req_ready, ENET_RST_N}, 3'b111);
  endtask

  task automatic do_txn(input bit w, input logic [7:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] cv, input bit keep, input int abort_at,
                        output int waited);
    req_write = w; req_addr = a; req_wdata = d; chip_val = cv; req_valid = 1'b1;
    waited = 0;
    while (!req_ready && waited < 200) begin
      tick();
      waited++;
    end
    chk("ready_wait", 64'(waited < 200), 64'd1);
    tick();
    if (!keep) req_valid = 1'b0;
    for (int k = 0; k < T; k++) begin
      if (k == abort_at) return;
      chk($sformatf("phase_k%0d", k), 64'(observed()), 64'(model(k, w, a, d)));
      tick();
    end
    if (!w) rdata_ref = cv;
    chk("rsp", {rsp_valid, req_ready, rsp_rdata}, {1'b1, 1'b1, rdata_ref});
    if (!keep) begin
      tick();
      chk("rsp_pulse", {rsp_valid, req_ready, rsp_rdata}, {1'b0, 1'b1, rdata_ref});
    end
  endtask

  initial begin
    int w;
    logic ih [0:39];
    // requests are presented before init completes and must be held off
    req_write = 1'b1; req_addr = 8'h1F; req_wdata = 16'h0001; req_valid = 1'b1;
    do_reset();
    do_txn(1'b1, 8'h1F, 16'h0001, 16'h0000, 1'b0, -1, w);
    do_txn(1'b0, 8'h28, 16'h0000, 16'h0A46, 1'b0, -1, w);

    // back-to-back: three accepts 25 cycles apart, no idle wait between them
    for (int i = 0; i < 3; i++) begin
      do_txn(1'($urandom), 8'($urandom), 16'($urandom), 16'($urandom), i < 2, -1, w);
      if (i > 0) chk("b2b_wait", 64'(w), 64'd0);
    end

    for (int i = 0; i < 8; i++)
      do_txn(1'($urandom), 8'($urandom), 16'($urandom), 16'($urandom), 1'b0, -1, w);

    // interrupt synchroniser: 3-cycle pulse then random levels
    for (int n = 0; n < 40; n++) begin
      chk("irq", 64'(irq), 64'(n >= 2 ? ih[n-2] : 1'b0));
      ih[n] = (n >= 5 && n < 8) ? 1'b1 : (n >= 15 ? 1'($urandom) : 1'b0);
      ENET_INT = ih[n];
      tick();
    end
    ENET_INT = 1'b0;

    // reset in the middle of the index-phase write strobe
    do_txn(1'b1, 8'($urandom), 16'($urandom), 16'h0000, 1'b0, 6, w);
    chk("abort_strobe_low", {ENET_WR_N, ENET_CS_N}, 2'b00);
    do_reset();
    do_txn(1'b0, 8'($urandom), 16'($urandom), 16'($urandom), 1'b0, -1, w);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
